uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised successor to the fixed 8-bit receiver inside uart_top.
- Receives asynchronous serial frames on rs232_rx using a 16x oversampling tick and 3-sample majority voting.
- Data width, bit order, stop bits and parity mode are configurable; baud divisor and parity are run-time inputs.
- Delivers each word with framing/parity status over a valid/ready handshake, and flags overrun and break conditions. Drops into uart_top in place of the existing receiver.

Parameters:
- DATA_W, 8: data bits per frame, 5..9.
- OVERSAMPLE, 16: ticks per bit; even, ≥8.
- DIV_W, 16: width of baud_div.
- MSB_FIRST, 1: 1 means the first data bit received is rx_data[DATA_W-1] (the existing link format); 0 means LSB first.
- STOP_BITS, 1: stop bits checked, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rs232_rx  in  1  serial line, idle high, asynchronous to clk.
- baud_div  in  DIV_W  clk cycles per oversample tick; values <2 are treated as 2.
- parity_mode  in  2  00 none, 01 odd, 10 even, 11 none.
- rx_data  out  DATA_W  received word.
- rx_valid  out  1  word available.
- rx_ready  in  1  consumer accepts the word.
- frame_err  out  1  stop bit(s) sampled low; qualified by rx_valid.
- parity_err  out  1  parity mismatch; qualified by rx_valid.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- break_det  out  1  level: line held low through a full frame; cleared when the line returns high.

Behaviour:
- rs232_rx passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised signal.
- Reset (asynchronous, any time, including mid-frame):
  - FSM goes to IDLE; tick and sample counters clear.
  - rx_data=0; rx_valid, frame_err, parity_err, overrun, break_det all 0.
  - A partially received frame is discarded.
- Tick generator:
  - Counter runs 0..div-1, where div = max(baud_div, 2); tick is high for one clk when count == div-1.
  - Counter is held at 0 in IDLE and restarts on start detection, so sampling is phase-aligned to the falling edge.
  - baud_div and parity_mode are latched at start detection; changes mid-frame have no effect.
- Sampling:
  - Sample counter s runs 0..OVERSAMPLE-1 per bit.
  - The bit value is the majority of the samples at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit decision is registered on the tick where s = OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE -> START when the synchronised line is 0.
  - START: a voted 1 is a glitch -> IDLE, with no outputs changed. A voted 0 -> DATA at the end of the bit (s = OVERSAMPLE-1).
  - DATA: shifts DATA_W bits in the MSB_FIRST order, then -> PARITY if parity_mode is 01/10, else -> STOP.
  - PARITY: the expected bit makes the total count of ones (data + parity) odd for 01, even for 10. Then -> STOP.
  - STOP: evaluates STOP_BITS bits; frame_err is set if any of them votes 0. The frame completes at the decision tick of the last stop bit; it does not wait for the end of the bit. Then -> IDLE if the last stop bit voted 1, else -> WAIT_HIGH.
  - WAIT_HIGH -> IDLE once the line is 1. No start detection while in WAIT_HIGH.
- break_det sets on completion when all data bits = 0, parity (if any) = 0 and frame_err = 1. It clears on the first clk the synchronised line is 1.
- Output register and handshake:
  - On completion: if rx_valid=0, or rx_valid & rx_ready in the same cycle, load rx_data/frame_err/parity_err and set rx_valid the next clk. Otherwise keep the old word and pulse overrun for one clk.
  - rx_valid stays high until rx_valid & rx_ready. Outputs are stable while rx_valid is high and not accepted.
- Latency: rx_valid rises 1 clk after the last stop-bit decision tick, plus 2 clk of synchroniser delay relative to the line.

Decomposition:
- Package uart_pkg:
  - state enum;
  - parity_mode encodings PAR_NONE, PAR_ODD, PAR_EVEN;
  - constant DIV_MIN = 2.
- One sub-module, uart_os_tick: the divisor counter with sync-restart input, producing the tick. It is shareable with a future parametrised transmitter.
- Synchroniser, FSM, shifter and output register stay in uart_rx_param.

Test Plan:
- Ordered data: 50 MHz clk, baud_div=27 (bit = 432 clk), 8N1, MSB_FIRST=1, send 0x00..0xFE with rx_ready=1 -> each byte is received with frame_err=0 and parity_err=0, and rx_valid pulses once per byte.
- Parity: parity_mode=10, send 0xA5 with parity bit 1 -> parity_err=1 and rx_data=0xA5. Same frame with parity_mode=01 -> parity_err=0.
- Glitch and noise:
  - A 3-tick low pulse on an idle line -> no rx_valid, FSM back in IDLE.
  - A single-tick inverted sample at mid-bit inside 0x3C -> 0x3C is still received.
- Framing and break:
  - Stop bit forced low on 0x55 -> frame_err=1.
  - Line held low for 20 bit times -> one word 0x00 with frame_err=1 and break_det=1. No new frame is detected until the line goes high; break_det then clears.
- Backpressure: rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once at 0x22's completion. With rx_ready asserted in exactly the completion cycle -> 0x22 is loaded and there is no overrun.
- Reset and config: assert rst_n=0 mid-data-bit -> all outputs are 0 within the same cycle, and the next full frame is received correctly. Also run DATA_W=7, STOP_BITS=2, MSB_FIRST=0: send 0x5A -> the value is received LSB-first, and a low second stop bit sets frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity encodings and divisor floor.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int DIV_MIN = 2;

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: counts 0..div-1 and pulses tick on the last count.
// Held at zero while disabled, so the first tick lands a full period after enable/restart.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;

  always_comb begin
    div_eff = (div < DIV_FLOOR) ? DIV_FLOOR : div;
  end

  assign tick = en && !restart && (cnt == (div_eff - DIV_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled 3-sample majority vote,
// optional parity, 1/2 stop bits, valid/ready output register with overrun and break flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int MSB_FIRST  = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rs232_rx,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              break_det
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] S_DEC = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic              rx_meta, rx_s;
  rx_state_e         state;
  logic [SW-1:0]     s_cnt;
  logic [3:0]        bit_cnt;
  logic              smp0, smp1;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              par_bit, ferr_acc;
  logic [1:0]        pmode_q;
  logic [DIV_W-1:0]  div_q;
  logic              tick, tick_en, start_det;
  logic              vote, dec, bit_end, par_en, done;
  logic              fe_new, pe_new, par_exp, brk_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rs232_rx;
      rx_s    <= rx_meta;
    end
  end

  assign start_det = (state == ST_IDLE) && !rx_s;
  assign tick_en   = (state != ST_IDLE) && (state != ST_WAIT_HIGH);

  uart_os_tick #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (tick_en),
    .restart (start_det),
    .div     (div_q),
    .tick    (tick)
  );

  always_comb begin
    vote    = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    dec     = tick && (s_cnt == S_DEC);
    bit_end = tick && (s_cnt == S_END);
    par_en  = (pmode_q == PAR_ODD) || (pmode_q == PAR_EVEN);
    done    = (state == ST_STOP) && dec && (bit_cnt == LAST_STOP);
    fe_new  = ferr_acc | ~vote;
    par_exp = (pmode_q == PAR_ODD) ? ~^shreg : ^shreg;
    pe_new  = par_en && (par_bit != par_exp);
    brk_new = (shreg == '0) && !(par_en && par_bit) && fe_new;
    if (MSB_FIRST != 0) shreg_nxt = {shreg[DATA_W-2:0], vote};
    else                shreg_nxt = {vote, shreg[DATA_W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      s_cnt    <= '0;
      bit_cnt  <= '0;
      smp0     <= 1'b1;
      smp1     <= 1'b1;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      pmode_q  <= PAR_NONE;
      div_q    <= '0;
    end else begin
      if (tick) begin
        s_cnt <= (s_cnt == S_END) ? '0 : s_cnt + SW'(1);
        if (s_cnt == S_V0) smp0 <= rx_s;
        if (s_cnt == S_V1) smp1 <= rx_s;
      end
      unique case (state)
        ST_IDLE: if (!rx_s) begin
          state    <= ST_START;
          s_cnt    <= '0;
          bit_cnt  <= '0;
          par_bit  <= 1'b0;
          ferr_acc <= 1'b0;
          pmode_q  <= parity_mode;
          div_q    <= baud_div;
        end
        ST_START: begin
          if (dec && vote) state <= ST_IDLE;
          else if (bit_end) state <= ST_DATA;
        end
        ST_DATA: begin
          if (dec) shreg <= shreg_nxt;
          if (bit_end) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (par_en) state <= ST_PARITY;
              else        state <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (dec) par_bit <= vote;
          if (bit_end) state <= ST_STOP;
        end
        // The frame completes at the last stop decision, not at the end of the bit.
        ST_STOP: begin
          if (dec) begin
            if (!vote) ferr_acc <= 1'b1;
            if (bit_cnt == LAST_STOP) begin
              if (vote) state <= ST_IDLE;
              else      state <= ST_WAIT_HIGH;
            end
          end else if (bit_end) begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        ST_WAIT_HIGH: if (rx_s) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          frame_err  <= fe_new;
          parity_err <= pe_new;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (done && brk_new) break_det <= 1'b1;
      else if (rx_s)       break_det <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 MSB-first instance and a 7-bit, 2-stop,
// LSB-first instance share the serial line; expected words are written out by hand.
module tb_uart_rx_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rs232_rx;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;

  logic [7:0] rx_data_a;
  logic       rx_valid_a, rx_ready_a, fe_a, pe_a, ovr_a, brk_a;
  logic [6:0] rx_data_b;
  logic       rx_valid_b, rx_ready_b, fe_b, pe_b, ovr_b, brk_b;

  int n_cmp = 0;
  int n_err = 0;
  int got_a = 0, got_b = 0, ovr_cnt_a = 0;
  logic [7:0] cap_data_a;
  logic       cap_fe_a, cap_pe_a;
  logic [6:0] cap_data_b;
  logic       cap_fe_b;

  int glitch_g = -100, glitch_len = 0, abort_g = -1, rdy_g = -10;
  int n0, o0;

  always #10 clk = ~clk;

  uart_rx_param #(.DATA_W(8), .OVERSAMPLE(16), .DIV_W(16), .MSB_FIRST(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rs232_rx(rs232_rx), .baud_div(baud_div),
    .parity_mode(parity_mode), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_ready(rx_ready_a), .frame_err(fe_a), .parity_err(pe_a),
    .overrun(ovr_a), .break_det(brk_a)
  );

  uart_rx_param #(.DATA_W(7), .OVERSAMPLE(16), .DIV_W(16), .MSB_FIRST(0), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rs232_rx(rs232_rx), .baud_div(baud_div),
    .parity_mode(parity_mode), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_ready(rx_ready_b), .frame_err(fe_b), .parity_err(pe_b),
    .overrun(ovr_b), .break_det(brk_b)
  );

  always @(negedge clk) begin
    if (rx_valid_a && rx_ready_a) begin
      got_a      <= got_a + 1;
      cap_data_a <= rx_data_a;
      cap_fe_a   <= fe_a;
      cap_pe_a   <= pe_a;
    end
    if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
    if (rx_valid_b && rx_ready_b) begin
      got_b      <= got_b + 1;
      cap_data_b <= rx_data_b;
      cap_fe_b   <= fe_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame, bit by bit, one clk per loop pass; g is the clk index from the start edge.
  task automatic tx_frame(input logic [8:0] d, input int nd, input bit msb, input bit has_par,
                          input logic par, input logic s1, input logic s2, input int nstop,
                          input int bc);
    logic [11:0] bits;
    logic        b;
    int          nb, g;
    bits = '1;
    bits[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < nd; i++) begin
      bits[nb] = msb ? d[nd-1-i] : d[i];
      nb++;
    end
    if (has_par) begin
      bits[nb] = par;
      nb++;
    end
    bits[nb] = s1;
    nb++;
    if (nstop == 2) begin
      bits[nb] = s2;
      nb++;
    end
    g = 0;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < bc; c++) begin
        @(negedge clk);
        if (g == abort_g) return;
        b = bits[i];
        if (g >= glitch_g && g < glitch_g + glitch_len) b = ~b;
        rs232_rx = b;
        if (g == rdy_g) rx_ready_a = 1'b1;
        else if (g == rdy_g + 1) rx_ready_a = 1'b0;
        g++;
      end
    end
    @(negedge clk);
    rs232_rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rs232_rx    = 1'b1;
    rst_n       = 1'b0;
    rx_ready_a  = 1'b1;
    rx_ready_b  = 1'b1;
    baud_div    = 16'd4;
    parity_mode = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_a", {rx_data_a, rx_valid_a, fe_a, pe_a, ovr_a, brk_a}, 0);
    chk("reset_b", {rx_data_b, rx_valid_b, fe_b, pe_b, ovr_b, brk_b}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Ordered sweep with baud_div=0, which must behave as 2 (bit = 32 clk).
    baud_div = 16'd0;
    for (int k = 0; k <= 17; k++) begin
      logic [7:0] v;
      v = (k == 17) ? 8'hFE : 8'(k * 15);
      n0 = got_a;
      tx_frame({1'b0, v}, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32);
      chk("sweep_cnt", got_a - n0, 1);
      chk("sweep_data", cap_data_a, v);
      chk("sweep_flags", {cap_fe_a, cap_pe_a}, 0);
    end

    // Nominal rate: baud_div=27, bit = 432 clk.
    baud_div = 16'd27;
    n0 = got_a;
    tx_frame(9'h096, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 432);
    chk("b27_cnt", got_a - n0, 1);
    chk("b27_data", cap_data_a, 8'h96);
    chk("b27_brk", brk_a, 0);

    // Parity: 0xA5 has four ones; parity bit 1 breaks even, satisfies odd.
    baud_div = 16'd4;
    parity_mode = 2'b10;
    n0 = got_a;
    tx_frame(9'h0A5, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 64);
    chk("even_cnt", got_a - n0, 1);
    chk("even_data", cap_data_a, 8'hA5);
    chk("even_pe", cap_pe_a, 1);
    chk("even_fe", cap_fe_a, 0);
    parity_mode = 2'b01;
    tx_frame(9'h0A5, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 64);
    chk("odd_data", cap_data_a, 8'hA5);
    chk("odd_pe", cap_pe_a, 0);
    parity_mode = 2'b00;

    // Three-tick low pulse on an idle line is rejected as a glitch.
    n0 = got_a;
    @(negedge clk);
    rs232_rx = 1'b0;
    repeat (12) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (12 * 64) @(negedge clk);
    chk("glitch_cnt", got_a - n0, 0);

    // One inverted tick at the middle sample of data bit 3 of 0x3C.
    glitch_g = 4 * 64 + 34;
    glitch_len = 4;
    tx_frame(9'h03C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 64);
    glitch_g = -100;
    glitch_len = 0;
    chk("noise_cnt", got_a - n0, 1);
    chk("noise_data", cap_data_a, 8'h3C);
    chk("noise_flags", {cap_fe_a, cap_pe_a}, 0);

    // Stop bit low.
    tx_frame(9'h055, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 64);
    chk("ferr_data", cap_data_a, 8'h55);
    chk("ferr_fe", cap_fe_a, 1);
    chk("ferr_pe", cap_pe_a, 0);

    // Break: line low for 20 bit times, then released.
    n0 = got_a;
    @(negedge clk);
    rs232_rx = 1'b0;
    repeat (20 * 64) @(negedge clk);
    chk("brk_cnt", got_a - n0, 1);
    chk("brk_data", cap_data_a, 8'h00);
    chk("brk_fe", cap_fe_a, 1);
    chk("brk_level", brk_a, 1);
    rs232_rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("brk_clear", brk_a, 0);
    repeat (3 * 64) @(negedge clk);
    chk("brk_no_restart", got_a - n0, 1);

    // Backpressure and overrun.
    rx_ready_a = 1'b0;
    o0 = ovr_cnt_a;
    tx_frame(9'h011, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 64);
    chk("bp_valid1", rx_valid_a, 1);
    chk("bp_data1", rx_data_a, 8'h11);
    tx_frame(9'h022, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 64);
    chk("bp_hold", rx_data_a, 8'h11);
    chk("bp_ovr", ovr_cnt_a - o0, 1);
    chk("bp_valid2", rx_valid_a, 1);
    // Ready only in the completion cycle: stop decision at clk 618 of the frame.
    rdy_g = 618;
    tx_frame(9'h022, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 64);
    rdy_g = -10;
    chk("ack_data", rx_data_a, 8'h22);
    chk("ack_ovr", ovr_cnt_a - o0, 1);
    chk("ack_valid", rx_valid_a, 1);

    // Asynchronous reset in the middle of a data bit, with a word still pending.
    abort_g = 3 * 64 + 20;
    tx_frame(9'h081, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 64);
    abort_g = -1;
    #2 rst_n = 1'b0;
    #1 chk("midrst_a", {rx_data_a, rx_valid_a, fe_a, pe_a, ovr_a, brk_a}, 0);
    @(negedge clk);
    rs232_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_ready_a = 1'b1;
    repeat (4) @(negedge clk);
    n0 = got_a;
    tx_frame(9'h0C3, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 64);
    chk("post_rst_cnt", got_a - n0, 1);
    chk("post_rst_data", cap_data_a, 8'hC3);
    chk("post_rst_flags", {cap_fe_a, cap_pe_a}, 0);

    // 7-bit, 2 stop bits, LSB first (0x5A reversed would read 0x2D).
    repeat (4 * 64) @(negedge clk);
    n0 = got_b;
    tx_frame(9'h05A, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 64);
    chk("b_cnt", got_b - n0, 1);
    chk("b_data", cap_data_b, 7'h5A);
    chk("b_fe", cap_fe_b, 0);
    tx_frame(9'h05A, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 64);
    chk("b_stop2_cnt", got_b - n0, 2);
    chk("b_stop2_data", cap_data_b, 7'h5A);
    chk("b_stop2_fe", cap_fe_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
